// File: rtl/activity_timer.sv
// Multi-channel millisecond event timer for the clk27 housekeeping domain.
// Each channel runs as an idle-timeout or a pulse-stretcher off a shared ms prescaler.
module activity_timer #(
  parameter int NUM_CH   = 4,
  parameter int TICK_DIV = 27000,
  parameter int MS_W     = 15
) (
  input  logic                     clk27,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        event_i,
  input  logic [NUM_CH-1:0]        edge_mode_i,
  input  logic [NUM_CH-1:0]        mode_i,
  input  logic [NUM_CH-1:0]        en_i,
  input  logic [NUM_CH*MS_W-1:0]   timeout_ms_i,
  output logic [NUM_CH-1:0]        status_o,
  output logic                     any_o,
  output logic                     tick_o
);

  localparam int              PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [MS_W-1:0] MS_MAX    = '1;

  logic [PW-1:0]     presc_q;
  logic              tick_d;
  logic [NUM_CH-1:0] sync1_q;
  logic [NUM_CH-1:0] sync2_q;
  logic [NUM_CH-1:0] prev_q;
  logic [NUM_CH-1:0] armed_q;
  logic [NUM_CH-1:0] ev;
  logic [NUM_CH-1:0] status_d;
  logic [MS_W-1:0]   ms_cnt [NUM_CH];

  // The counters advance on the same edge that registers tick_o, so they see tick_d.
  assign tick_d = (presc_q == PRESC_MAX);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk27 or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      tick_o  <= 1'b0;
    end else begin
      presc_q <= tick_d ? '0 : presc_q + PW'(1);
      tick_o  <= tick_d;
    end
  end

  // NOTE: event_i may be asynchronous, so two flops settle metastability before any logic looks at it.
  always_ff @(posedge clk27 or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= event_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  always_comb begin
    ev = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ev[c] = edge_mode_i[c] ? (sync2_q[c] & ~prev_q[c]) : (sync2_q[c] ^ prev_q[c]);
    end
  end

  // NOTE: the counter array is a handful of flops, not a RAM, so it takes the reset like any other state.
  always_ff @(posedge clk27 or posedge reset) begin
    if (reset) begin
      armed_q <= '0;
      for (int c = 0; c < NUM_CH; c++) ms_cnt[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (en_i[c]) begin
          if (ev[c]) begin
            ms_cnt[c]  <= '0;
            armed_q[c] <= 1'b1;
          end else if (tick_d && ms_cnt[c] != MS_MAX) begin
            ms_cnt[c] <= ms_cnt[c] + MS_W'(1);
          end
        end
      end
    end
  end

  // NOTE: status_d gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    status_d = status_o;
    for (int c = 0; c < NUM_CH; c++) begin
      if (en_i[c]) begin
        if (timeout_ms_i[c*MS_W +: MS_W] == '0)
          status_d[c] = 1'b0;
        else if (mode_i[c])
          status_d[c] = armed_q[c] & (ms_cnt[c] < timeout_ms_i[c*MS_W +: MS_W]);
        else
          status_d[c] = (ms_cnt[c] >= timeout_ms_i[c*MS_W +: MS_W]);
      end
    end
  end

  always_ff @(posedge clk27 or posedge reset) begin
    if (reset) begin
      status_o <= '0;
      any_o    <= 1'b0;
    end else begin
      status_o <= status_d;
      any_o    <= |status_d;
    end
  end

endmodule

// File: tb/tb_activity_timer.sv
// Directed bench for activity_timer: TICK_DIV=10, narrow counters so saturation is reachable.
module tb_activity_timer;

  localparam int NUM_CH   = 4;
  localparam int TICK_DIV = 10;
  localparam int MS_W     = 12;

  logic                   clk27 = 1'b0;
  logic                   reset = 1'b1;
  logic [NUM_CH-1:0]      event_i = '0;
  logic [NUM_CH-1:0]      edge_mode_i = '0;
  logic [NUM_CH-1:0]      mode_i = '0;
  logic [NUM_CH-1:0]      en_i = '0;
  logic [NUM_CH*MS_W-1:0] timeout_ms_i = '0;
  logic [NUM_CH-1:0]      status_o;
  logic                   any_o;
  logic                   tick_o;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk27 = ~clk27;

  activity_timer #(.NUM_CH(NUM_CH), .TICK_DIV(TICK_DIV), .MS_W(MS_W)) dut (
    .clk27        (clk27),
    .reset        (reset),
    .event_i      (event_i),
    .edge_mode_i  (edge_mode_i),
    .mode_i       (mode_i),
    .en_i         (en_i),
    .timeout_ms_i (timeout_ms_i),
    .status_o     (status_o),
    .any_o        (any_o),
    .tick_o       (tick_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Advance to 1 time unit after clock edge k (edges counted from reset release).
  task automatic go_to(input int k);
    while (cyc < k) begin
      @(posedge clk27);
      #1;
      cyc++;
    end
  endtask

  function automatic logic [NUM_CH*MS_W-1:0] pack_t(input logic [MS_W-1:0] t0, input logic [MS_W-1:0] t1,
                                                     input logic [MS_W-1:0] t2, input logic [MS_W-1:0] t3);
    return {t3, t2, t1, t0};
  endfunction

  initial begin
    en_i         = 4'hF;
    edge_mode_i  = 4'b0010;
    mode_i       = 4'b0110;
    timeout_ms_i = pack_t(12'd3, 12'd2, 12'd5, 12'd0);
    @(posedge clk27);
    @(posedge clk27);
    #1;
    reset = 1'b0;
    cyc   = 0;

    check("rst_status", 32'(status_o), 32'h0);
    check("rst_any",    32'(any_o),    32'h0);
    check("rst_tick",   32'(tick_o),   32'h0);

    go_to(9);   check("tick_9",  32'(tick_o), 32'h0);
    go_to(10);  check("tick_10", 32'(tick_o), 32'h1);
    go_to(11);  check("tick_11", 32'(tick_o), 32'h0);

    // Idle timeout from reset: ch0 T=3 rises one cycle after the third tick.
    go_to(30);  check("idle_ch0_30", 32'(status_o[0]), 32'h0);
                check("any_30",      32'(any_o),       32'h0);
    go_to(31);  check("idle_ch0_31", 32'(status_o[0]), 32'h1);
                check("any_31",      32'(any_o),       32'h1);
    go_to(60);  check("stretch_unarmed_ch2", 32'(status_o[2]), 32'h0);
                check("t0_ch3_60",           32'(status_o[3]), 32'h0);

    // Stretch on rising edge: ch1 T=2.
    go_to(100); check("ch1_pre", 32'(status_o[1]), 32'h0);
    event_i[1] = 1'b1;
    go_to(103); check("ch1_103", 32'(status_o[1]), 32'h0);
    go_to(104); check("ch1_104", 32'(status_o[1]), 32'h1);
    go_to(105); event_i[1] = 1'b0;
    go_to(120); check("ch1_120", 32'(status_o[1]), 32'h1);
    go_to(121); check("ch1_121", 32'(status_o[1]), 32'h0);

    // Toggle ch0 every 25 cycles; clears at 160 and 210 coincide with ticks.
    go_to(132); event_i[0] = 1'b1;
    go_to(135); check("tog_ch0_135", 32'(status_o[0]), 32'h1);
    go_to(136); check("tog_ch0_136", 32'(status_o[0]), 32'h0);
    go_to(157); event_i[0] = 1'b0;
    go_to(160); check("ev_tick_cnt_160", 32'(dut.ms_cnt[0]), 32'h0);
    go_to(181); check("tog_ch0_181", 32'(status_o[0]), 32'h0);
    go_to(182); event_i[0] = 1'b1;
    go_to(206); check("tog_ch0_206", 32'(status_o[0]), 32'h0);
    go_to(207); event_i[0] = 1'b0;
    go_to(210); check("ev_tick_cnt_210", 32'(dut.ms_cnt[0]), 32'h0);
    go_to(240); check("quiet_ch0_240", 32'(status_o[0]), 32'h0);
    go_to(241); check("quiet_ch0_241", 32'(status_o[0]), 32'h1);

    // ch2 stretch T=5 (any edge), frozen by en_i[2] while event_i[2] toggles.
    go_to(300); event_i[2] = 1'b1;
    go_to(304); check("ch2_arm_304", 32'(status_o[2]), 32'h1);
    go_to(322); en_i[2] = 1'b0;
    go_to(325); event_i[2] = 1'b0;
    go_to(330); event_i[2] = 1'b1;
    go_to(335); event_i[2] = 1'b0;
    go_to(345); check("dis_cnt_345",    32'(dut.ms_cnt[2]), 32'h2);
                check("dis_status_345", 32'(status_o[2]),   32'h1);
    en_i[2] = 1'b1;
    go_to(350); check("reen_cnt_350",    32'(dut.ms_cnt[2]), 32'h3);
                check("reen_status_350", 32'(status_o[2]),   32'h1);
    go_to(370); check("reen_status_370", 32'(status_o[2]),   32'h1);
    go_to(371); check("reen_status_371", 32'(status_o[2]),   32'h0);

    // Reset mid-stretch clears outputs without waiting for a clock edge.
    go_to(400); event_i[2] = 1'b1;
    go_to(406); check("pre_rst_ch2", 32'(status_o[2]), 32'h1);
                check("pre_rst_any", 32'(any_o),       32'h1);
    reset = 1'b1;
    #1;
    check("async_rst_status", 32'(status_o), 32'h0);
    check("async_rst_any",    32'(any_o),    32'h0);
    check("async_rst_cnt2",   32'(dut.ms_cnt[2]), 32'h0);

    // Long run: ch0 T=all-ones in mode 0, ch1/ch3 T=0.
    event_i      = '0;
    edge_mode_i  = '0;
    mode_i       = 4'b0100;
    timeout_ms_i = pack_t(12'hFFF, 12'd0, 12'd5, 12'd0);
    @(posedge clk27);
    @(posedge clk27);
    #1;
    reset = 1'b0;
    cyc   = 0;

    go_to(20000); check("t0_ch3_20000", 32'(status_o[3]), 32'h0);
                  check("t0_ch1_20000", 32'(status_o[1]), 32'h0);
    go_to(40950); check("sat_ch0_40950", 32'(status_o[0]), 32'h0);
                  check("sat_any_40950", 32'(any_o),       32'h0);
    go_to(40951); check("sat_ch0_40951", 32'(status_o[0]), 32'h1);
                  check("sat_any_40951", 32'(any_o),       32'h1);
    go_to(41000); check("sat_cnt0",   32'(dut.ms_cnt[0]), 32'hFFF);
                  check("sat_cnt3",   32'(dut.ms_cnt[3]), 32'hFFF);
                  check("t0_ch3_sat", 32'(status_o[3]),   32'h0);
                  check("tick_41000", 32'(tick_o),        32'h1);
    timeout_ms_i = pack_t(12'hFFF, 12'd0, 12'd5, 12'd5);
    go_to(41001); check("rt_change_ch3", 32'(status_o[3]), 32'h1);
                  check("tick_41001",    32'(tick_o),      32'h0);
                  check("rt_keep_cnt3",  32'(dut.ms_cnt[3]), 32'hFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
